// File: rtl/ifc_struct_sched_if.sv
// Request/response bundle between NREQ producers and the shared offset-adder scheduler.
// master = requester side, slave = scheduler side.
interface ifc_struct_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_value;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_val100;
    logic [31:0]        rsp_val200;
    logic [NREQ-1:0]    outstanding;
    logic [15:0]        issue_cnt;

    modport master (
        output req_valid, req_value,
        input  req_ready, rsp_valid, rsp_id, rsp_val100, rsp_val200, outstanding, issue_cnt
    );

    modport slave (
        input  req_valid, req_value,
        output req_ready, rsp_valid, rsp_id, rsp_val100, rsp_val200, outstanding, issue_cnt
    );
endinterface

// File: rtl/ifc_struct_sched.sv
// Round-robin share of one value+offset pipeline between NREQ requesters, tagged results.
// Latency: result pulses LAT cycles after the grant cycle; one issue per cycle.
// Backpressure: req_ready only for requesters without a result in flight; responses cannot stall.
module ifc_struct_sched #(
    parameter int NREQ  = 4,
    parameter int LAT   = 2,
    parameter int OFS_A = 100,
    parameter int OFS_B = 200,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    ifc_struct_sched_if.slave bus
);
    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    v100;
        logic [31:0]    v200;
    } rsp_t;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic [IDW-1:0]  cidx;
    int              sidx;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] out_q, out_d;
    logic [15:0]     cnt_q;
    logic [LAT-1:0]  vld_q;
    rsp_t            pipe_q [LAT];
    rsp_t            req_s;

    // Grant is gated by rst_n so req_ready stays low while reset is held.
    always_comb begin
        elig  = bus.req_valid & ~out_q;
        grant = '0;
        gidx  = '0;
        cidx  = '0;
        sidx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            sidx = int'(ptr_q) + k;
            if (sidx >= NREQ) sidx = sidx - NREQ;
            cidx = IDW'(sidx);
            if (rst_n && grant == '0 && elig[cidx]) begin
                grant[cidx] = 1'b1;
                gidx        = cidx;
            end
        end

        ptr_d = ptr_q;
        if (|grant) ptr_d = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;

        out_d = out_q;
        if (vld_q[LAT-1]) out_d[pipe_q[LAT-1].id] = 1'b0;
        out_d = out_d | grant;

        req_s.id   = gidx;
        req_s.v100 = bus.req_value[{gidx, 5'b00000} +: 32] + OFS_A;
        req_s.v200 = bus.req_value[{gidx, 5'b00000} +: 32] + OFS_B;
    end

    // Data stages only load behind a valid, so the final stage holds the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            out_q <= '0;
            cnt_q <= '0;
            vld_q <= '0;
            for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
        end else begin
            ptr_q    <= ptr_d;
            out_q    <= out_d;
            vld_q[0] <= |grant;
            if (|grant) begin
                cnt_q     <= cnt_q + 16'd1;
                pipe_q[0] <= req_s;
            end
            for (int k = 1; k < LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign bus.req_ready   = grant;
    assign bus.rsp_valid   = vld_q[LAT-1];
    assign bus.rsp_id      = pipe_q[LAT-1].id;
    assign bus.rsp_val100  = pipe_q[LAT-1].v100;
    assign bus.rsp_val200  = pipe_q[LAT-1].v200;
    assign bus.outstanding = out_q;
    assign bus.issue_cnt   = cnt_q;
endmodule

// File: tb/tb_ifc_struct_sched.sv
// Bench for ifc_struct_sched: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ifc_struct_sched;
    localparam int NREQ  = 4;
    localparam int LAT   = 2;
    localparam int OFS_A = 100;
    localparam int OFS_B = 200;
    localparam int IDW   = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ifc_struct_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    ifc_struct_sched #(.NREQ(NREQ), .LAT(LAT), .OFS_A(OFS_A), .OFS_B(OFS_B), .IDW(IDW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference model: in-flight list with countdowns in acceptance order.
    typedef struct {
        int          id;
        logic [31:0] v;
        int          rem;
    } fl_t;

    fl_t             fl[$];
    int              m_ptr;
    logic [NREQ-1:0] m_out;
    logic [15:0]     m_cnt;
    int              m_total;
    logic [IDW-1:0]  m_rid;
    logic [31:0]     m_v100, m_v200;
    int              cyc = 0;

    int          acc_ids[$];
    int          acc_cyc[$];
    int          rsp_ids[$];
    int          rsp_cyc[$];
    logic [31:0] rsp_a[$];
    logic [31:0] rsp_b[$];

    function automatic logic [31:0] val_of(int i);
        return 32'(bus.req_value >> (32 * i));
    endfunction

    always @(negedge clk) begin
        logic            exp_vld;
        logic [NREQ-1:0] eg;
        int              gi, idx;
        cyc++;
        if (!rst_n) begin
            chk("reset_state",
                {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.outstanding, bus.issue_cnt, bus.rsp_val100[7:0]},
                '0);
            chk("reset_val200", bus.rsp_val200, 0);
            fl.delete();
            m_ptr = 0; m_out = '0; m_cnt = '0; m_total = 0;
            m_rid = '0; m_v100 = '0; m_v200 = '0;
        end else begin
            exp_vld = (fl.size() > 0) && (fl[0].rem == 0);
            if (exp_vld) begin
                m_rid  = IDW'(fl[0].id);
                m_v100 = fl[0].v + 32'(OFS_A);
                m_v200 = fl[0].v + 32'(OFS_B);
            end
            eg = '0; gi = 0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (eg == '0 && bus.req_valid[idx[IDW-1:0]] && !m_out[idx[IDW-1:0]]) begin
                    eg[idx[IDW-1:0]] = 1'b1;
                    gi = idx;
                end
            end
            chk("req_ready", bus.req_ready, eg);
            chk("rsp_valid", bus.rsp_valid, exp_vld);
            chk("rsp_id", bus.rsp_id, m_rid);
            chk("rsp_val100", bus.rsp_val100, m_v100);
            chk("rsp_val200", bus.rsp_val200, m_v200);
            chk("outstanding", bus.outstanding, m_out);
            chk("issue_cnt", bus.issue_cnt, m_cnt);
            if (bus.rsp_valid) begin
                rsp_ids.push_back(int'(bus.rsp_id));
                rsp_a.push_back(bus.rsp_val100);
                rsp_b.push_back(bus.rsp_val200);
                rsp_cyc.push_back(cyc);
            end
            // Advance across the coming rising edge.
            if (exp_vld) begin
                m_out[fl[0].id[IDW-1:0]] = 1'b0;
                void'(fl.pop_front());
            end
            foreach (fl[i]) fl[i].rem--;
            if (eg != '0) begin
                fl.push_back('{id: gi, v: val_of(gi), rem: LAT - 1});
                m_out[gi[IDW-1:0]] = 1'b1;
                m_ptr = (gi + 1) % NREQ;
                m_cnt++;
                m_total++;
                acc_ids.push_back(gi);
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_ids.delete(); acc_cyc.delete();
        rsp_ids.delete(); rsp_cyc.delete(); rsp_a.delete(); rsp_b.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        step();
        step();
        rst_n = 1'b1;
        clear_logs();
    endtask

    initial begin
        logic [NREQ-1:0] v;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_value = '0;
        step(); step(); step();
        rst_n = 1'b1;

        // Single request on requester 0.
        do_reset();
        bus.req_value = {32'd0, 32'd0, 32'd0, 32'd5};
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = '0;
        step(); step(); step(); step();
        chk("single_acc_n", acc_ids.size(), 1);
        chk("single_rsp_n", rsp_ids.size(), 1);
        chk("single_id", rsp_ids[0], 0);
        chk("single_v100", rsp_a[0], 105);
        chk("single_v200", rsp_b[0], 205);
        chk("single_lat", rsp_cyc[0] - acc_cyc[0], 2);
        chk("single_cnt", bus.issue_cnt, 1);

        // Fairness with all four requesters valid.
        do_reset();
        bus.req_value = {32'd40, 32'd30, 32'd20, 32'd10};
        bus.req_valid = 4'b1111;
        repeat (16) step();
        bus.req_valid = '0;
        step(); step(); step(); step();
        chk("fair_acc_n", acc_ids.size() >= 8, 1);
        for (int i = 0; i < 8; i++) chk("fair_order", acc_ids[i], i % 4);
        chk("fair_back2back", acc_cyc[3] - acc_cyc[0], 3);
        for (int i = 0; i < 4; i++) begin
            chk("fair_rsp_id", rsp_ids[i], i);
            chk("fair_rsp_v100", rsp_a[i], 110 + 10 * i);
        end

        // Single requester 2 blocks on its own outstanding result.
        do_reset();
        bus.req_value = {32'd0, 32'd7, 32'd0, 32'd0};
        bus.req_valid = 4'b0100;
        repeat (12) step();
        bus.req_valid = '0;
        step(); step(); step(); step();
        chk("block_acc_n", acc_ids.size(), 4);
        for (int i = 1; i < 4; i++) chk("block_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
        chk("block_rsp_n", rsp_ids.size(), 4);
        foreach (rsp_ids[i]) chk("block_rsp_id", rsp_ids[i], 2);

        // Two's-complement wrap.
        do_reset();
        bus.req_value = {32'd0, 32'd0, 32'hFFFF_FFC0, 32'd0};
        bus.req_valid = 4'b0010;
        step();
        bus.req_valid = '0;
        step(); step(); step();
        chk("wrap_rsp_n", rsp_ids.size(), 1);
        chk("wrap_v100", rsp_a[0], 32'h0000_0024);
        chk("wrap_v200", rsp_b[0], 32'h0000_0088);

        // Reset while two results are in flight.
        do_reset();
        bus.req_value = {32'd4, 32'd3, 32'd2, 32'd1};
        bus.req_valid = 4'b0011;
        step();
        step();
        rst_n = 1'b0;
        bus.req_valid = '0;
        chk("mid_acc_n", acc_ids.size(), 2);
        clear_logs();
        step();
        rst_n = 1'b1;
        step(); step(); step(); step();
        chk("mid_no_rsp", rsp_ids.size(), 0);
        chk("mid_outstanding", bus.outstanding, 0);
        chk("mid_cnt", bus.issue_cnt, 0);
        bus.req_valid = 4'b1001;
        step();
        bus.req_valid = '0;
        step(); step(); step();
        chk("mid_next_grant", acc_ids[0], 0);

        // Randomised traffic, with valids toggling and values changing freely.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            v = bus.req_valid ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            bus.req_valid = v;
            bus.req_value = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 7) == 0) bus.req_value[31:0] = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            step();
        end
        bus.req_valid = '0;
        step(); step(); step(); step();

        // Issue counter wrap after 65537 acceptances.
        do_reset();
        bus.req_value = {$urandom, $urandom, $urandom, $urandom};
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 70000 && m_total < 65537; n++) step();
        bus.req_valid = '0;
        chk("cntwrap_reached", m_total, 65537);
        step(); step();
        chk("cntwrap_value", bus.issue_cnt, 1);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
